// File: rtl/req_gnt_monitor.sv
// Multi-channel req/gnt handshake monitor: checks that every request rise is
// answered by a grant rise within [MIN_LAT, MAX_LAT] cycles and keeps sticky flags plus counters.
module req_gnt_monitor #(
    parameter int NUM_CH  = 4,
    parameter int MIN_LAT = 1,
    parameter int MAX_LAT = 1,
    parameter int CNT_W   = 16,
    localparam int LAT_W  = $clog2(MAX_LAT + 1),
    localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] gnt,
    input  logic [NUM_CH-1:0] err_clr,
    input  logic              cnt_clr,
    input  logic [SEL_W-1:0]  stat_sel,
    output logic [NUM_CH-1:0] err_late,
    output logic [NUM_CH-1:0] err_early,
    output logic [NUM_CH-1:0] err_spur,
    output logic [NUM_CH-1:0] err_drop,
    output logic              err_any,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt
);

    typedef enum logic {IDLE, WAIT} state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [LAT_W-1:0] LAT_MIN = LAT_W'(MIN_LAT);
    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAX_LAT);
    localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);

    state_e state_q [NUM_CH];
    state_e state_d [NUM_CH];

    logic [NUM_CH-1:0]            req_q, req_d, gnt_q, gnt_d;
    logic [NUM_CH-1:0]            rose_r, rose_g;
    logic [NUM_CH-1:0][LAT_W-1:0] lat_q, lat_d;
    logic [NUM_CH-1:0]            late_q, late_d, early_q, early_d;
    logic [NUM_CH-1:0]            spur_q, spur_d, drop_q, drop_d;
    logic [NUM_CH-1:0]            set_late, set_early, set_spur, set_drop, pass_ev;
    logic [NUM_CH-1:0][CNT_W-1:0] pass_q, pass_d, fail_q, fail_d;

    assign rose_r = req & ~req_q;
    assign rose_g = gnt & ~gnt_q;

    always_comb begin
        req_d     = req;
        gnt_d     = gnt;
        lat_d     = lat_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        set_late  = '0;
        set_early = '0;
        set_spur  = '0;
        set_drop  = '0;
        pass_ev   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE: begin
                    // A simultaneous req/gnt rise is spurious yet still opens a new wait.
                    if (rose_g[i]) set_spur[i] = 1'b1;
                    if (rose_r[i]) begin
                        state_d[i] = WAIT;
                        lat_d[i]   = LAT_ONE;
                    end
                end
                WAIT: begin
                    if (rose_g[i]) begin
                        if (lat_q[i] < LAT_MIN) set_early[i] = 1'b1;
                        else                    pass_ev[i]   = 1'b1;
                        state_d[i] = IDLE;
                    end else if (!req[i]) begin
                        set_drop[i] = 1'b1;
                        state_d[i]  = IDLE;
                    end else if (lat_q[i] == LAT_MAX) begin
                        set_late[i] = 1'b1;
                        state_d[i]  = IDLE;
                    end else begin
                        lat_d[i] = lat_q[i] + 1'b1;
                    end
                end
            endcase
            // One fail increment per cycle no matter how many flags fire together.
            if (cnt_clr) begin
                pass_d[i] = '0;
                fail_d[i] = '0;
            end else begin
                if (pass_ev[i] && pass_q[i] != CNT_MAX) pass_d[i] = pass_q[i] + 1'b1;
                if ((set_late[i] | set_early[i] | set_spur[i] | set_drop[i]) &&
                    fail_q[i] != CNT_MAX)
                    fail_d[i] = fail_q[i] + 1'b1;
            end
        end
        late_d  = set_late  | (late_q  & ~err_clr);
        early_d = set_early | (early_q & ~err_clr);
        spur_d  = set_spur  | (spur_q  & ~err_clr);
        drop_d  = set_drop  | (drop_q  & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= '0;
            gnt_q   <= '0;
            lat_q   <= '0;
            late_q  <= '0;
            early_q <= '0;
            spur_q  <= '0;
            drop_q  <= '0;
            pass_q  <= '0;
            fail_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) state_q[i] <= IDLE;
        end else begin
            req_q   <= req_d;
            gnt_q   <= gnt_d;
            lat_q   <= lat_d;
            late_q  <= late_d;
            early_q <= early_d;
            spur_q  <= spur_d;
            drop_q  <= drop_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            for (int i = 0; i < NUM_CH; i++) state_q[i] <= state_d[i];
        end
    end

    always_comb begin
        pass_cnt = '0;
        fail_cnt = '0;
        if (int'(stat_sel) < NUM_CH) begin
            pass_cnt = pass_q[stat_sel];
            fail_cnt = fail_q[stat_sel];
        end
    end

    assign err_late  = late_q;
    assign err_early = early_q;
    assign err_spur  = spur_q;
    assign err_drop  = drop_q;
    assign err_any   = |{late_q, early_q, spur_q, drop_q};

endmodule

// File: tb/tb_req_gnt_monitor.sv
// Directed bench for req_gnt_monitor: default, windowed-latency and
// narrow-counter instances driven from a vector table and hand-written sequences.
module tb_req_gnt_monitor;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    // Default instance: NUM_CH=4, MIN_LAT=MAX_LAT=1, CNT_W=16
    logic [3:0]  d_req, d_gnt, d_clr, d_late, d_early, d_spur, d_drop;
    logic        d_cclr, d_any;
    logic [1:0]  d_sel;
    logic [15:0] d_pass, d_fail;

    req_gnt_monitor u_def (
        .clk(clk), .rst_n(rst_n), .req(d_req), .gnt(d_gnt), .err_clr(d_clr),
        .cnt_clr(d_cclr), .stat_sel(d_sel), .err_late(d_late), .err_early(d_early),
        .err_spur(d_spur), .err_drop(d_drop), .err_any(d_any),
        .pass_cnt(d_pass), .fail_cnt(d_fail)
    );

    // Windowed instance: MIN_LAT=2, MAX_LAT=4
    logic [3:0]  w_req, w_gnt, w_clr, w_late, w_early, w_spur, w_drop;
    logic        w_cclr, w_any;
    logic [1:0]  w_sel;
    logic [15:0] w_pass, w_fail;

    req_gnt_monitor #(.NUM_CH(4), .MIN_LAT(2), .MAX_LAT(4), .CNT_W(16)) u_win (
        .clk(clk), .rst_n(rst_n), .req(w_req), .gnt(w_gnt), .err_clr(w_clr),
        .cnt_clr(w_cclr), .stat_sel(w_sel), .err_late(w_late), .err_early(w_early),
        .err_spur(w_spur), .err_drop(w_drop), .err_any(w_any),
        .pass_cnt(w_pass), .fail_cnt(w_fail)
    );

    // Saturation instance: NUM_CH=3 (so stat_sel=3 is out of range), CNT_W=3
    logic [2:0] s_req, s_gnt, s_clr, s_late, s_early, s_spur, s_drop;
    logic       s_cclr, s_any;
    logic [1:0] s_sel;
    logic [2:0] s_pass, s_fail;

    req_gnt_monitor #(.NUM_CH(3), .MIN_LAT(1), .MAX_LAT(1), .CNT_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .req(s_req), .gnt(s_gnt), .err_clr(s_clr),
        .cnt_clr(s_cclr), .stat_sel(s_sel), .err_late(s_late), .err_early(s_early),
        .err_spur(s_spur), .err_drop(s_drop), .err_any(s_any),
        .pass_cnt(s_pass), .fail_cnt(s_fail)
    );

    typedef struct {
        logic [3:0]  req, gnt, clr;
        logic        cclr;
        logic [1:0]  sel;
        logic [3:0]  late, early, spur, drop;
        logic        any;
        logic [15:0] pass, fail;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        d_req  = v.req;
        d_gnt  = v.gnt;
        d_clr  = v.clr;
        d_cclr = v.cclr;
        d_sel  = v.sel;
        tick();
    endtask

    initial begin
        // req gnt clr cclr sel | late early spur drop any pass fail  (channel 0)
        vecs[0]  = '{4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 16'd0, 16'd0};
        vecs[1]  = '{4'h1, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 16'd0, 16'd0};
        vecs[2]  = '{4'h0, 4'h1, 4'h0, 1'b0, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 16'd1, 16'd0};
        vecs[3]  = '{4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 16'd1, 16'd0};
        vecs[4]  = '{4'h1, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 16'd1, 16'd0};
        vecs[5]  = '{4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0, 4'h0, 4'h0, 4'h1, 1'b1, 16'd1, 16'd1};
        vecs[6]  = '{4'h0, 4'h0, 4'h1, 1'b0, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 16'd1, 16'd1};
        vecs[7]  = '{4'h1, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 16'd1, 16'd1};
        vecs[8]  = '{4'h1, 4'h0, 4'h0, 1'b0, 2'd0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1, 16'd1, 16'd2};
        vecs[9]  = '{4'h1, 4'h0, 4'h0, 1'b0, 2'd0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1, 16'd1, 16'd2};
        vecs[10] = '{4'h1, 4'h0, 4'h1, 1'b0, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 16'd1, 16'd2};
        vecs[11] = '{4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 16'd1, 16'd2};
        vecs[12] = '{4'h0, 4'h1, 4'h0, 1'b0, 2'd0, 4'h0, 4'h0, 4'h1, 4'h0, 1'b1, 16'd1, 16'd3};
        vecs[13] = '{4'h0, 4'h0, 4'h1, 1'b0, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 16'd1, 16'd3};
        vecs[14] = '{4'h1, 4'h1, 4'h0, 1'b0, 2'd0, 4'h0, 4'h0, 4'h1, 4'h0, 1'b1, 16'd1, 16'd4};
        vecs[15] = '{4'h1, 4'h1, 4'h0, 1'b0, 2'd0, 4'h1, 4'h0, 4'h1, 4'h0, 1'b1, 16'd1, 16'd5};
        vecs[16] = '{4'h0, 4'h0, 4'h1, 1'b0, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 16'd1, 16'd5};
        vecs[17] = '{4'h0, 4'h1, 4'h1, 1'b0, 2'd0, 4'h0, 4'h0, 4'h1, 4'h0, 1'b1, 16'd1, 16'd6};
        vecs[18] = '{4'h0, 4'h0, 4'h1, 1'b0, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 16'd1, 16'd6};
        vecs[19] = '{4'h0, 4'h0, 4'h0, 1'b0, 2'd1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 16'd0, 16'd0};
        vecs[20] = '{4'h0, 4'h0, 4'h0, 1'b1, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 16'd0, 16'd0};

        rst_n = 1'b0;
        d_req = '0; d_gnt = '0; d_clr = '0; d_cclr = 1'b0; d_sel = '0;
        w_req = '0; w_gnt = '0; w_clr = '0; w_cclr = 1'b0; w_sel = '0;
        s_req = '0; s_gnt = '0; s_clr = '0; s_cclr = 1'b0; s_sel = 2'd2;
        tick();
        tick();
        checkOutput("rst_def_flags", {d_late, d_early, d_spur, d_drop}, 32'h0);
        checkOutput("rst_def_any", d_any, 32'h0);
        checkOutput("rst_def_cnt", {d_pass, d_fail}, 32'h0);
        checkOutput("rst_win_flags", {w_late, w_early, w_spur, w_drop, w_any}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("[TB] default-parameter vector table");
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d_late", i), d_late, vecs[i].late);
            checkOutput($sformatf("v%0d_early", i), d_early, vecs[i].early);
            checkOutput($sformatf("v%0d_spur", i), d_spur, vecs[i].spur);
            checkOutput($sformatf("v%0d_drop", i), d_drop, vecs[i].drop);
            checkOutput($sformatf("v%0d_any", i), d_any, vecs[i].any);
            checkOutput($sformatf("v%0d_pass", i), d_pass, vecs[i].pass);
            checkOutput($sformatf("v%0d_fail", i), d_fail, vecs[i].fail);
        end
        d_clr = '0; d_cclr = 1'b0;

        $display("[TB] latency window 2..4");
        w_req = 4'b1110;
        tick();
        w_gnt = 4'b0010;
        tick();
        checkOutput("win_early_lat1", w_early, 32'h2);
        checkOutput("win_late_none", w_late, 32'h0);
        tick();
        tick();
        checkOutput("win_late_before_max", w_late, 32'h0);
        w_gnt = 4'b0110;
        tick();
        checkOutput("win_late_ch3", w_late, 32'h8);
        checkOutput("win_early_held", w_early, 32'h2);
        checkOutput("win_spur_drop", {w_spur, w_drop}, 32'h0);
        w_sel = 2'd2; #1;
        checkOutput("win_pass_ch2", w_pass, 32'd1);
        checkOutput("win_fail_ch2", w_fail, 32'd0);
        w_sel = 2'd1; #1;
        checkOutput("win_fail_ch1", w_fail, 32'd1);
        w_sel = 2'd3; #1;
        checkOutput("win_fail_ch3", w_fail, 32'd1);
        w_sel = 2'd0; #1;
        checkOutput("win_ch0_idle", {w_pass, w_fail}, 32'h0);
        w_req = '0; w_gnt = '0;
        tick();
        checkOutput("win_no_drop", w_drop, 32'h0);
        w_req = 4'b0010;
        tick();
        tick();
        w_gnt = 4'b0010;
        tick();
        w_sel = 2'd1; #1;
        checkOutput("win_pass_lat2", w_pass, 32'd1);
        checkOutput("win_early_sticky", w_early, 32'h2);

        $display("[TB] counter saturation and reset");
        for (int i = 0; i < 8; i++) begin
            s_req = 3'b100; s_gnt = 3'b000;
            tick();
            s_req = 3'b000; s_gnt = 3'b100;
            tick();
            if (i == 6) checkOutput("sat_pass_7", s_pass, 32'd7);
        end
        checkOutput("sat_pass_hold", s_pass, 32'd7);
        checkOutput("sat_fail_zero", s_fail, 32'd0);
        s_sel = 2'd3; #1;
        checkOutput("sat_sel_oob", {s_pass, s_fail}, 32'h0);
        s_sel = 2'd2;
        s_req = 3'b100; s_gnt = 3'b000;
        tick();
        s_req = 3'b000; s_gnt = 3'b100; s_cclr = 1'b1;
        tick();
        s_cclr = 1'b0;
        checkOutput("sat_clr_wins", s_pass, 32'd0);
        s_req = 3'b100; s_gnt = 3'b000;
        tick();
        s_req = 3'b000; s_gnt = 3'b100;
        tick();
        checkOutput("sat_pass_after_clr", s_pass, 32'd1);
        s_gnt = 3'b000;
        tick();
        s_gnt = 3'b001;
        tick();
        checkOutput("sat_spur_ch0", s_spur, 32'h1);
        s_req = 3'b100;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_flags", {s_late, s_early, s_spur, s_drop, s_any}, 32'h0);
        checkOutput("rst_async_cnt", {s_pass, s_fail}, 32'h0);
        s_req = '0; s_gnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        checkOutput("rst_abort_flags", {s_late, s_early, s_spur, s_drop, s_any}, 32'h0);
        checkOutput("rst_abort_cnt", {s_pass, s_fail}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/req_gnt_monitor.md
Name: req_gnt_monitor

Overview:
- Synthesizable, multi-channel req/gnt handshake protocol monitor.
- Every request rise must be answered by a grant rise within a programmable latency window [MIN_LAT, MAX_LAT] cycles.
- Per channel it provides sticky error flags, saturating pass/fail counters, and an aggregate error output.
- Sits beside any arbiter or slave interface as an always-on checker in silicon and in simulation.

Parameters:
- NUM_CH, 4: number of independent req/gnt channels (>=1).
- MIN_LAT, 1: earliest legal grant rise, in cycles after the request rise sample (>=1).
- MAX_LAT, 1: latest legal grant rise (>=MIN_LAT). The defaults give "grant rises exactly on the next cycle".
- CNT_W, 16: width of the pass and fail counters.
- Localparam LAT_W = $clog2(MAX_LAT+1).
- Localparam SEL_W = max(1, $clog2(NUM_CH)).

Ports:
- clk, input, 1: sampling clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- req, input, NUM_CH: request per channel.
- gnt, input, NUM_CH: grant per channel.
- err_clr, input, NUM_CH: per-channel pulse that clears that channel's sticky flags.
- cnt_clr, input, 1: pulse that clears all counters of all channels.
- stat_sel, input, SEL_W: channel select for the counter readout.
- err_late, output, NUM_CH: sticky flag, grant missing by MAX_LAT.
- err_early, output, NUM_CH: sticky flag, grant rose before MIN_LAT.
- err_spur, output, NUM_CH: sticky flag, grant rose with no pending request.
- err_drop, output, NUM_CH: sticky flag, request fell before grant.
- err_any, output, 1: OR of all sticky flags of all channels.
- pass_cnt, output, CNT_W: pass counter of channel stat_sel.
- fail_cnt, output, CNT_W: fail counter of channel stat_sel.

Behaviour:
- Reset (rst_n low, async):
  - req_q, gnt_q, all flags and all counters clear to 0.
  - Every channel FSM goes to IDLE; the latency counter clears to 0.
  - All outputs therefore read 0 during and after reset.
- Edge detect per channel:
  - rose_r = req & ~req_q and rose_g = gnt & ~gnt_q, where req_q/gnt_q hold the previous-cycle samples.
  - A signal already high at reset release is seen as a rise on the first clock.
- FSM per channel, states IDLE and WAIT; lat is LAT_W bits.
- IDLE:
  - rose_g sets err_spur.
  - rose_r moves to WAIT with lat<=1. This happens even if rose_g is also set that cycle, so a simultaneous rise is spurious and a new wait starts.
- WAIT, priority order per cycle:
  1. rose_g: if lat<MIN_LAT, set err_early; else it is a pass. Go to IDLE.
  2. else if req==0: set err_drop and go to IDLE.
  3. else if lat==MAX_LAT: set err_late and go to IDLE.
  4. else lat<=lat+1.
- A grant rise in the same cycle as the request falls counts as a grant, under rule 1.
- Latency definition: the grant rise sampled on the cycle after the request rise is latency 1.
- Counters:
  - Pass increments the channel's pass_cnt.
  - Each cycle in which at least one error flag is set for a channel increments that channel's fail_cnt by exactly 1.
  - Both counters saturate at 2^CNT_W-1; no wrap.
  - cnt_clr has priority over increment in the same cycle.
- Sticky flags:
  - Set on the error event and held until err_clr[i].
  - If a set and a clear land in the same cycle, set wins.
  - err_clr does not affect the FSM or the counters.
- Readout:
  - pass_cnt and fail_cnt are combinational muxes on stat_sel.
  - If stat_sel >= NUM_CH, both read 0.
  - err_any is a combinational OR of the registered flags.
- Channels are fully independent; no cross-channel interaction.
- Reset mid-WAIT aborts the check with no error recorded.

Test Plan:
- Default params, ch0: req 0->1 at cycle 10, gnt 0->1 and req 1->0 at cycle 11 -> pass_cnt[0]=1, fail_cnt=0, all flags 0, err_any=0.
- Default params, ch0: req rises at cycle 23, gnt stays 0, req falls at cycle 24 -> err_drop[0]=1 at cycle 25, fail_cnt=1, err_any=1.
- Default params, ch0: req rises, held high, gnt never rises -> err_late[0] set one cycle after lat reaches 1, fail_cnt=1; err_clr[0] pulse -> flags 0, fail_cnt remains 1.
- MIN_LAT=2, MAX_LAT=4:
  - ch1: gnt rises at latency 1 -> err_early[1].
  - ch2: gnt rises at latency 4 -> pass.
  - ch3: latency 5 -> err_late[3] at lat 4.
  - Channel 0 unaffected.
- ch0 gnt rises while idle, and separately req and gnt rise together -> err_spur[0]=1 in each case; the second case enters WAIT and then flags err_late.
- CNT_W=3: eight passes on ch2 -> pass_cnt saturates at 7. cnt_clr together with a pass -> counter 0. rst_n asserted mid-WAIT -> all outputs 0 immediately.
